// File: rtl/janela_pkg.sv
// janela_pkg
// Shared definitions for the 3x3 window generator: pixel width, the packed
// window type (element 0 = E0, top-left; element 8 = E8, bottom-right) and
// the default image geometry.
package janela_pkg;

  localparam int PIXEL_W     = 8;
  localparam int LARGURA_PAD = 16;
  localparam int ALTURA_PAD  = 16;

  typedef logic [8:0][PIXEL_W-1:0] janela_t;

endpackage

// File: rtl/buffer_linha.sv
// buffer_linha
// One image row of pixel storage, single port, read-before-write: dout is
// the word stored at addr before the write that happens on this rising edge.
// Contents are deliberately not reset.
//   clk  : clock
//   we   : write enable
//   addr : column address
//   din  : pixel written at addr
//   dout : pixel currently stored at addr (combinational read)
module buffer_linha
  import janela_pkg::*;
#(
  parameter int LARGURA = LARGURA_PAD
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(LARGURA)-1:0] addr,
  input  logic [PIXEL_W-1:0]         din,
  output logic [PIXEL_W-1:0]         dout
);

  logic [PIXEL_W-1:0] mem [LARGURA];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
  end

  assign dout = mem[addr];

endmodule

// File: rtl/filtro.sv
// filtro
// Registered median of a 3x3 window. Only built when
// GERADOR_JANELA_MEDIANA_EN is defined.
//   clk, rst      : clock, asynchronous active-high reset
//   janela        : registered window from gerador_janela
//   janela_valid  : window is new this cycle
//   mediana       : median of the last valid window (holds otherwise)
//   mediana_valid : one cycle after janela_valid
`ifdef GERADOR_JANELA_MEDIANA_EN
module filtro
  import janela_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  janela_t            janela,
  input  logic               janela_valid,
  output logic [PIXEL_W-1:0] mediana,
  output logic               mediana_valid
);

  // Full sort of the nine samples; the fifth smallest is the median.
  function automatic logic [PIXEL_W-1:0] mediana9(input janela_t w);
    janela_t            v;
    logic [PIXEL_W-1:0] t;
    v = w;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8 - i; j++) begin
        if (v[j] > v[j+1]) begin
          t      = v[j];
          v[j]   = v[j+1];
          v[j+1] = t;
        end
      end
    end
    return v[4];
  endfunction

  logic [PIXEL_W-1:0] med_q, med_d;
  logic               mv_q, mv_d;

  always_comb begin
    med_d = janela_valid ? mediana9(janela) : med_q;
    mv_d  = janela_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      med_q <= '0;
      mv_q  <= 1'b0;
    end else begin
      med_q <= med_d;
      mv_q  <= mv_d;
    end
  end

  assign mediana       = med_q;
  assign mediana_valid = mv_q;

endmodule
`endif

// File: rtl/gerador_janela.sv
// gerador_janela
// Builds a sliding 3x3 window over a raster pixel stream using two line
// buffers. A window is emitted only when all nine pixels belong to the
// current frame (row >= 2, col >= 2), so stale line-buffer data from an
// earlier or aborted frame can never reach the outputs.
// Optional feature: define GERADOR_JANELA_MEDIANA_EN to add a registered
// median filter (ports mediana, mediana_valid).
//   clk, rst      : clock, asynchronous active-high reset
//   pixel_in      : raster-order pixel
//   pixel_valid   : pixel_in accepted on this edge
//   sof           : accepted pixel is (0,0)
//   E0..E8        : window, row-major, E4 centre
//   janela_valid  : E0..E8 are new this cycle
//   eof           : last window of the frame
module gerador_janela
  import janela_pkg::*;
#(
  parameter int LARGURA = LARGURA_PAD,
  parameter int ALTURA  = ALTURA_PAD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pixel_in,
  input  logic       pixel_valid,
  input  logic       sof,
  output logic [7:0] E0,
  output logic [7:0] E1,
  output logic [7:0] E2,
  output logic [7:0] E3,
  output logic [7:0] E4,
  output logic [7:0] E5,
  output logic [7:0] E6,
  output logic [7:0] E7,
  output logic [7:0] E8,
  output logic       janela_valid,
  output logic       eof
`ifdef GERADOR_JANELA_MEDIANA_EN
  ,
  output logic [7:0] mediana,
  output logic       mediana_valid
`endif
);

  localparam int CW = $clog2(LARGURA);
  localparam int RW = $clog2(ALTURA);
  localparam logic [CW-1:0] COL_MAX  = CW'(LARGURA - 1);
  localparam logic [RW-1:0] ROW_MAX  = RW'(ALTURA - 1);
  localparam logic [CW-1:0] COL_UM   = CW'(1);
  localparam logic [RW-1:0] ROW_UM   = RW'(1);
  localparam logic [CW-1:0] COL_DOIS = CW'(2);
  localparam logic [RW-1:0] ROW_DOIS = RW'(2);

  logic [CW-1:0]      col_q, col_d, col_eff;
  logic [RW-1:0]      row_q, row_d, row_eff;
  janela_t            win_q, win_d;
  janela_t            saida_q, saida_d;
  logic               jv_q, jv_d;
  logic               eof_q, eof_d;
  logic               qualifica;
  logic [PIXEL_W-1:0] rd_r1, rd_r2;

  // Row r-1 buffer takes the incoming pixel; row r-2 buffer takes what row
  // r-1 held at this column, so rows age by one on every pass.
  buffer_linha #(.LARGURA(LARGURA)) u_linha_1 (
    .clk  (clk),
    .we   (pixel_valid),
    .addr (col_eff),
    .din  (pixel_in),
    .dout (rd_r1)
  );

  buffer_linha #(.LARGURA(LARGURA)) u_linha_2 (
    .clk  (clk),
    .we   (pixel_valid),
    .addr (col_eff),
    .din  (rd_r1),
    .dout (rd_r2)
  );

  always_comb begin
    // sof forces the accepted pixel to (0,0) whatever the counters say.
    col_eff = sof ? '0 : col_q;
    row_eff = sof ? '0 : row_q;

    col_d = col_q;
    row_d = row_q;
    if (pixel_valid) begin
      if (col_eff == COL_MAX) begin
        col_d = '0;
        row_d = (row_eff == ROW_MAX) ? '0 : row_eff + ROW_UM;
      end else begin
        col_d = col_eff + COL_UM;
        row_d = row_eff;
      end
    end

    win_d = win_q;
    if (pixel_valid) begin
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = rd_r2;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = rd_r1;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = pixel_in;
    end

    qualifica = pixel_valid && (row_eff >= ROW_DOIS) && (col_eff >= COL_DOIS);
    saida_d   = qualifica ? win_d : saida_q;
    jv_d      = qualifica;
    eof_d     = qualifica && (row_eff == ROW_MAX) && (col_eff == COL_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '0;
      saida_q <= '0;
      jv_q    <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      saida_q <= saida_d;
      jv_q    <= jv_d;
      eof_q   <= eof_d;
    end
  end

  assign E0 = saida_q[0];
  assign E1 = saida_q[1];
  assign E2 = saida_q[2];
  assign E3 = saida_q[3];
  assign E4 = saida_q[4];
  assign E5 = saida_q[5];
  assign E6 = saida_q[6];
  assign E7 = saida_q[7];
  assign E8 = saida_q[8];
  assign janela_valid = jv_q;
  assign eof          = eof_q;

`ifdef GERADOR_JANELA_MEDIANA_EN
  filtro u_filtro (
    .clk           (clk),
    .rst           (rst),
    .janela        (saida_q),
    .janela_valid  (jv_q),
    .mediana       (mediana),
    .mediana_valid (mediana_valid)
  );
`endif

endmodule

// File: doc/gerador_janela.md
GERADOR_JANELA -- requirements
Module: gerador_janela

Interface
REQ-001 Parameter LARGURA, default 16, image width in pixels; legal range 3..1024.
REQ-002 Parameter ALTURA, default 16, image height in rows; legal range 3..1024.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 pixel_in  input  8  raster-order pixel, left to right, top to bottom.
REQ-006 pixel_valid  input  1  pixel_in accepted on a rising edge when high; no backpressure.
REQ-007 sof  input  1  start of frame; qualified by pixel_valid; marks pixel at (row 0, col 0).
REQ-008 E0..E8  output  8 each  3x3 window, row-major: E0..E2 row r-2, E3..E5 row r-1, E6..E8 row r; E4 is center.
REQ-009 janela_valid  output  1  E0..E8 hold a new complete window for one cycle.
REQ-010 eof  output  1  high together with janela_valid on the last window of a frame.

Function
REQ-011 Column counter 0..LARGURA-1 and row counter 0..ALTURA-1 advance only on accepted pixels.
REQ-012 Column wraps LARGURA-1 -> 0 with row increment; row wraps ALTURA-1 -> 0, an implicit new frame.
REQ-013 Accepted pixel with sof high is taken as (0,0), regardless of counter state; partial frame is discarded.
REQ-014 sof with pixel_valid low is ignored.
REQ-015 Two line buffers of LARGURA x 8 bits hold rows r-1 and r-2; at column c, read before write, same cycle.
REQ-016 Window is a 3x3 register array shifting one column left per accepted pixel; new column = {buf r-2[c], buf r-1[c], pixel_in}.
REQ-017 Window is emitted for accepted pixel (r,c) only when r>=2 and c>=2; no border windows, no padding.
REQ-018 Latency: pixel accepted at edge k -> janela_valid and E0..E8 registered at edge k, visible for exactly the cycle following k.
REQ-019 janela_valid low on every cycle without an accepted qualifying pixel; E0..E8 hold last values when janela_valid is low.
REQ-020 Windows per frame = (LARGURA-2)*(ALTURA-2); eof asserted only for pixel (ALTURA-1, LARGURA-1).
REQ-021 Gaps of any length in pixel_valid shall not change window content or order.
REQ-022 Line buffer contents from a discarded partial frame shall never appear in an emitted window.

Reset
REQ-023 rst high: counters 0; E0..E8 = 8'h00; janela_valid = 0; eof = 0; window registers 0.
REQ-024 Line buffer memory is not reset; REQ-017 guarantees stale data is never emitted.
REQ-025 Reset mid-frame aborts the frame; first accepted pixel after release is (0,0) with or without sof.

Configuration
REQ-026 Macro GERADOR_JANELA_MEDIANA_EN defined: block instantiates filtro on the registered window and adds outputs mediana (8) and mediana_valid (1), registered, one cycle after janela_valid; both reset to 0.
REQ-027 Macro undefined: mediana and mediana_valid ports do not exist; no filtro instance.

Structure
REQ-028 Shared package janela_pkg holds PIXEL_W = 8, the window typedef (9 x 8-bit array) and default LARGURA/ALTURA constants.
REQ-029 One sub-module buffer_linha: parameterised LARGURA x 8 single-port read-before-write memory, instantiated twice.
REQ-030 Counter widths are $clog2 of LARGURA and ALTURA; no other arithmetic in the datapath.

Verification (LARGURA=4, ALTURA=4, pixel = {row[3:0], col[3:0]})
REQ-031 Continuous frame with sof on first pixel -> first janela_valid one cycle after pixel 8'h22, E0..E8 = 00 01 02 10 11 12 20 21 22; exactly 4 windows per frame.
REQ-032 Same frame -> last window E0..E8 = 11 12 13 21 22 23 31 32 33 with eof = 1; eof low on the other 3.
REQ-033 Random 0-5 cycle gaps in pixel_valid -> identical 4 windows in identical order; janela_valid never high during a gap.
REQ-034 sof re-asserted at pixel (1,2) of an in-progress frame -> no window until new-frame pixel (2,2), which yields 00 01 02 10 11 12 20 21 22.
REQ-035 rst pulsed during row 2 -> all outputs 0 in the next cycle; next frame without sof produces the REQ-031 windows.
REQ-036 With GERADOR_JANELA_MEDIANA_EN defined -> mediana = 8'h11 one cycle after the first window; load 9 pixels {00,FF,...} in a window -> mediana equals the sorted 5th value.
